// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a time,
// and hands each fetched word with its address to decode. Redirects flush and squash.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_inst_valid;
  logic [31:0] r_inst_data;
  logic [31:0] r_inst_pc;
  logic        r_fault;

  logic w_req_valid;
  logic w_req_fire;
  logic w_redir_ok;
  logic w_redir_bad;
  logic w_load;

  // A request only goes out when the output register is free by the time the
  // response can land, so a live response never meets an occupied register.
  assign w_req_valid = !rst && (r_state == S_REQ) && (!r_inst_valid || inst_ready);
  assign w_req_fire  = w_req_valid && imem_req_ready;
  assign w_redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00) && (r_state != S_FAULT);
  assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00) && (r_state != S_FAULT);
  assign w_load      = (r_state == S_WAIT) && imem_resp_valid && !redirect_valid;

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_nxt; no latch.
    w_state_nxt = r_state;
    unique case (r_state)
      S_REQ: begin
        if (w_redir_bad)     w_state_nxt = S_FAULT;
        else if (w_redir_ok) w_state_nxt = w_req_fire ? S_DROP : S_REQ;
        else if (w_req_fire) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_redir_bad)          w_state_nxt = S_FAULT;
        else if (imem_resp_valid) w_state_nxt = S_REQ;
        else if (w_redir_ok)      w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (w_redir_bad)          w_state_nxt = S_FAULT;
        else if (imem_resp_valid) w_state_nxt = S_REQ;
      end
      S_FAULT: w_state_nxt = S_FAULT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_req_pc     <= 32'h0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_fault      <= 1'b0;
    end else begin
      if (w_redir_ok)      r_pc <= redirect_pc;
      else if (w_req_fire) r_pc <= r_pc + 32'd4;

      if (w_req_fire) r_req_pc <= r_pc;

      if (w_redir_ok || w_redir_bad) begin
        r_inst_valid <= 1'b0;
      end else if (w_load) begin
        r_inst_valid <= 1'b1;
        r_inst_data  <= imem_resp_data;
        r_inst_pc    <= r_req_pc;
      end else if (r_inst_valid && inst_ready) begin
        r_inst_valid <= 1'b0;
      end

      if (w_redir_bad) r_fault <= 1'b1;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;
  assign fetch_fault    = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_ready = 1'b0;

  logic        imem_req_valid, inst_valid, fetch_fault;
  logic [31:0] imem_req_addr, inst_data, inst_pc;
  logic        b_req_valid, b_inst_valid, b_fetch_fault;
  logic [31:0] b_req_addr, b_inst_data, b_inst_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
  );

  // Second instance shares all inputs; only its wrap-around address is examined.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(b_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(b_inst_valid), .inst_ready(inst_ready),
    .inst_data(b_inst_data), .inst_pc(b_inst_pc), .fetch_fault(b_fetch_fault)
  );

  int n_vec = 0;
  int n_err = 0;

  // Memory environment: one pending read, replies after mem_lat extra cycles.
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  int          mem_lat  = 0;
  logic [31:0] mem_addr = 32'h0;

  // Reference model: PC, decode slot, one pending fetch that is live or squashed.
  logic [31:0] m_pc    = 32'h0;
  bit          m_ov    = 1'b0;
  logic [31:0] m_od    = 32'h0;
  logic [31:0] m_opc   = 32'h0;
  bit          m_fault = 1'b0;
  bit          m_pend  = 1'b0;
  bit          m_live  = 1'b0;
  logic [31:0] m_paddr = 32'h0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input bit ir, input bit rr, input bit rv,
                      input logic [31:0] rpc, input bit rs);
    bit exp_rv, fire, resp;
    @(negedge clk);
    rst            = rs;
    inst_ready     = ir;
    imem_req_ready = rr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_resp_valid = mem_busy && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? word_at(mem_addr) : 32'hDEAD_BEEF;
    #1;
    exp_rv = !rs && !m_fault && !m_pend && (!m_ov || ir);
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", imem_req_addr, m_pc);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, m_ov});
    if (m_ov) begin
      check("inst_data", inst_data, m_od);
      check("inst_pc", inst_pc, m_opc);
    end
    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});

    if (imem_resp_valid)  mem_busy = 1'b0;
    else if (mem_busy)    mem_cnt--;
    if (imem_req_valid && imem_req_ready) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = imem_req_addr;
    end
    if (rs) mem_busy = 1'b0;

    fire = exp_rv && rr;
    resp = m_pend && imem_resp_valid;
    if (rs) begin
      m_pc = 32'h0; m_ov = 0; m_od = 32'h0; m_opc = 32'h0;
      m_fault = 0; m_pend = 0; m_live = 0;
    end else if (!m_fault) begin
      if (rv && rpc[1:0] != 2'b00) begin
        m_fault = 1; m_ov = 0; m_pend = 0;
      end else if (rv) begin
        m_pc = rpc;
        m_ov = 0;
        if (fire)      begin m_pend = 1; m_live = 0; end
        else if (resp) m_pend = 0;
        else           m_live = 0;
      end else begin
        if (resp && m_live) begin
          m_ov = 1; m_od = word_at(m_paddr); m_opc = m_paddr;
        end else if (m_ov && ir) begin
          m_ov = 0;
        end
        if (resp) m_pend = 0;
        if (fire) begin
          m_pend = 1; m_live = 1; m_paddr = m_pc; m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    mem_lat = 0;
    tick(1, 1, 0, 32'h0, 1);
    tick(1, 1, 0, 32'h0, 1);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    tick(1, 1, 0, 32'h0, 0);
    check("first_req", imem_req_addr, 32'h0);
    check("wrap_first_req", b_req_addr, 32'hFFFF_FFFC);
    tick(1, 1, 0, 32'h0, 0);
    check("wait_no_req", {31'b0, imem_req_valid}, 32'h0);
    tick(1, 1, 0, 32'h0, 0);
    check("inst0_pc", inst_pc, 32'h0);
    check("req_4", imem_req_addr, 32'h4);
    check("wrap_second_req", b_req_addr, 32'h0);
    tick(1, 1, 0, 32'h0, 0);
    tick(1, 1, 0, 32'h0, 0);
    check("inst1_pc", inst_pc, 32'h4);
    tick(1, 1, 0, 32'h0, 0);
    tick(0, 1, 0, 32'h0, 0);
    check("inst2_pc", inst_pc, 32'h8);
    check("stall_no_req", {31'b0, imem_req_valid}, 32'h0);
    tick(0, 1, 0, 32'h0, 0);
    check("stall_hold_data", inst_data, word_at(32'h8));
    mem_lat = 1;
    tick(1, 1, 0, 32'h0, 0);
    check("release_req", imem_req_addr, 32'hC);
    tick(1, 1, 1, 32'h100, 0);
    mem_lat = 0;
    tick(1, 1, 0, 32'h0, 0);
    check("drop_no_inst", {31'b0, inst_valid}, 32'h0);
    tick(1, 1, 0, 32'h0, 0);
    check("redir_req", imem_req_addr, 32'h100);
    tick(1, 1, 0, 32'h0, 0);
    tick(1, 1, 1, 32'h200, 0);
    check("redir_inst_pc", inst_pc, 32'h100);
    check("same_cycle_req", imem_req_addr, 32'h104);
    tick(1, 1, 0, 32'h0, 0);
    check("flushed", {31'b0, inst_valid}, 32'h0);
    tick(1, 1, 1, 32'h102, 0);
    check("req_200", imem_req_addr, 32'h200);
    tick(1, 1, 0, 32'h0, 0);
    check("fault_set", {31'b0, fetch_fault}, 32'h1);
    tick(1, 1, 1, 32'h300, 0);
    check("fault_no_req", {31'b0, imem_req_valid}, 32'h0);
    tick(1, 1, 0, 32'h0, 1);
    tick(1, 1, 0, 32'h0, 0);
    check("restart_req", imem_req_addr, 32'h0);
    check("fault_cleared", {31'b0, fetch_fault}, 32'h0);

    for (int i = 0; i < 4000; i++) begin
      int          r;
      bit          rv, rs;
      logic [31:0] rpc;
      r       = $urandom_range(0, 199);
      rv      = (r < 10);
      rpc     = $urandom & 32'hFFFF_FFFC;
      if (r == 0)     rpc = $urandom | 32'h1;
      else if (r < 4) rpc = 32'hFFFF_FFF8;
      rs      = ($urandom_range(0, 299) == 0) || (m_fault && $urandom_range(0, 19) == 0);
      mem_lat = $urandom_range(0, 3);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rv, rpc, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. Holds the program counter and issues word reads to instruction memory over a valid/ready request channel. Presents each fetched instruction with its PC to decode over a valid/ready handshake. Accepts PC redirects from the branch/jump unit, flushing the fetched instruction and discarding any in-flight memory response.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be 4-byte aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `redirect_valid` in 1: branch/jump unit requests a PC change this cycle.
- `redirect_pc` in 32: new PC, sampled when `redirect_valid`=1.
- `imem_req_valid` out 1: read request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: byte address of the word to read.
- `imem_resp_valid` in 1: read data valid. Has no backpressure and arrives ≥1 cycle after request acceptance.
- `imem_resp_data` in 32: instruction word.
- `inst_valid` out 1: instruction presented to decode.
- `inst_ready` in 1: decode consumes the instruction this cycle.
- `inst_data` out 32: instruction word.
- `inst_pc` out 32: address of `inst_data`.
- `fetch_fault` out 1: sticky misaligned-redirect fault.

## Operation
- Registers:
  - `pc`: next address to request.
  - `req_pc`: address of the outstanding request.
  - output register: `inst_valid`/`inst_data`/`inst_pc`.
  - `fault`.
  - `state`.
- At most one memory request is outstanding.
- States and transitions:
  - REQ: `imem_req_valid` = `!inst_valid || inst_ready`, with `imem_req_addr` = `pc`. On handshake (`imem_req_valid && imem_req_ready`): `req_pc`<=`pc`, `pc`<=`pc`+4, go to WAIT.
  - WAIT: `imem_req_valid`=0. On `imem_resp_valid`: load the output register (`inst_data`<=`imem_resp_data`, `inst_pc`<=`req_pc`, `inst_valid`<=1), go to REQ. The REQ gating guarantees the output register is free.
  - DROP: `imem_req_valid`=0. On `imem_resp_valid`: discard the data, go to REQ.
  - FAULT: all request and instruction valids are 0. Only `rst` exits.
- Output register: cleared when `inst_valid && inst_ready` and not reloaded the same edge. Contents are held stable while `inst_valid && !inst_ready`.
- Redirect (`redirect_valid`=1, aligned) has priority over every other event in that cycle:
  - `pc`<=`redirect_pc`; `inst_valid`<=0 (flush, even if `inst_ready`=1).
  - From REQ with no handshake: stay in REQ.
  - From REQ with a handshake in the same cycle: the request was already issued to the old `pc`, so go to DROP.
  - From WAIT with no response this cycle: go to DROP.
  - From WAIT with a response this cycle: discard the response, go to REQ.
  - From DROP: update `pc`, stay in DROP. If a response arrives the same cycle, discard it and go to REQ.
- Misaligned redirect (`redirect_pc[1:0]`≠0): `fault`<=1, `inst_valid`<=0, go to FAULT. Redirects and responses are ignored in FAULT.
- `pc`+4 wraps modulo 2^32 (`32'hFFFF_FFFC` → `32'h0000_0000`).
- `imem_req_valid` does not depend on `redirect_valid`. A redirect does not withdraw a request in the same cycle.

## Timing
- While `rst`=1: `imem_req_valid`=0, `inst_valid`=0, `fetch_fault`=0, `inst_data`=0, `inst_pc`=0, `pc`=`RESET_PC`, state=REQ.
- First cycle after `rst` falls: `imem_req_valid`=1 with `imem_req_addr`=`RESET_PC`.
- Reset asserted mid-operation (WAIT/DROP/FAULT): the next state is REQ. A late response from before reset is a system error and is not handled.
- Response in cycle N → `inst_valid`=1 in cycle N+1. The next request is also asserted in N+1 if the `inst_valid`/`inst_ready` gating allows.
- Peak throughput: 1 instruction per 2 cycles with a 1-cycle memory.
- Aligned redirect at edge N from REQ or WAIT-with-response: request to `redirect_pc` asserted in cycle N+1. From WAIT without response or DROP: asserted the cycle after the discarded response.
- `fetch_fault` rises the cycle after the misaligned redirect and stays high until `rst`.

## Test plan
- Reset release, 1-cycle memory, `inst_ready`=1 → requests at 0x0, 0x4, 0x8 on alternating cycles; decode receives words with `inst_pc` 0x0, 0x4, 0x8.
- Hold `inst_ready`=0 after the first instruction → no further request. `inst_data`/`inst_pc`=0x0 stay stable. Raising `inst_ready` gives the request for 0x4 in the same cycle.
- Redirect to 0x100 while in WAIT (response for 0x8 two cycles later) → response for 0x8 discarded, never presented. Next request addr=0x100; decode sees `inst_pc`=0x100.
- Redirect to 0x200 in the same cycle as a REQ handshake for 0xC → DROP. The 0xC response is discarded; the next request is 0x200.
- `RESET_PC`=0xFFFF_FFFC → second request address is 0x0000_0000.
- Redirect to 0x102 → `fetch_fault`=1 next cycle, no further `imem_req_valid`/`inst_valid` until `rst`. After `rst`, fetch restarts at `RESET_PC`.
